micromips_mc_control: RTL
=========================

// Module: micromips_mc_control
// PURPOSE
//  Multicycle control FSM for the MicroMIPS datapath. It succeeds the single-cycle controlunit.
//  Decodes op/fn from the shared instruction/data memory read and sequences the datapath through
//  FETCH/DECODE/EXEC/MEM/WB, with a memory ready handshake, an illegal-instruction trap and a retired-instruction counter.
// PARAMETERS
//  MEM_HS   1   1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored (treated as 1)
//  TRAP_EN  1   1: undecoded instr -> TRAP state; 0: undecoded instr retires as NOP
//  CNT_W    16  width of retire_cnt
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  op            in   6      opcode from memory read data (sampled in FETCH only)
//  fn            in   6      function field from memory read data (sampled in FETCH only)
//  mem_ready     in   1      memory access complete this cycle
//  pc_write      out  1      unconditional PC load
//  pc_write_cond out  1      PC load if branch condition (brtype) true
//  ir_write      out  1      instruction register load
//  inst_data     out  1      memory address select: 0=PC, 1=ALU result register z
//  data_read     out  1      memory read strobe
//  data_write    out  1      memory write strobe
//  reg_write     out  1      register file write enable
//  reg_dst       out  2      00=rt, 01=rd, 10=$31
//  reg_insrc     out  2      00=memory data, 01=ALU result, 10=PC (link)
//  alu_srcx      out  1      0=PC, 1=rs
//  alu_srcy      out  2      00=+4, 01=rt, 10=imm, 11=4*imm
//  add_sub       out  1      0=add, 1=sub
//  logic_fn      out  2      00=and, 01=or, 10=xor, 11=nor
//  fn_class      out  2      00=lui, 01=set-less, 10=arith, 11=logic
//  brtype        out  2      00=none, 01=beq, 10=bne, 11=bltz
//  PCsrc         out  2      00=ALU, 01=jump addr, 10=rs, 11=z (branch target)
//  jump_addr     out  1      0=instruction target, 1=syscall/trap vector
//  illegal       out  1      one-cycle pulse in TRAP for undecoded instr
//  retire_cnt    out  CNT_W  completed-instruction count
// BEHAVIOUR
//  Encodings:
//   - op 000000 R-type, fn: add 100000, sub 100010, slt 101010, and 100100, or 100101, xor 100110,
//     nor 100111, jr 001000, syscall 001100.
//   - op: lui 001111, addi 001000, slti 001010, andi 001100, ori 001101, xori 001110, lw 100011,
//     sw 101011, j 000010, jal 000011, bltz 000001, beq 000100, bne 000101. Anything else is undecoded.
//  States: FETCH, DECODE, EXEC, MEMRD, MEMWR, WBALU, WBMEM, TRAP.
//  Outputs: Moore, decoded from state and op_q/fn_q. Every output not listed for a state is 0 (never x).
//  rst=1: next edge state=FETCH, op_q=fn_q=0, retire_cnt=0; all outputs forced 0 while rst=1.
//   - Reset mid-operation abandons any pending memory access.
//  FETCH: data_read=1, inst_data=0, alu_srcx=0, alu_srcy=00, add_sub=0, fn_class=10, PCsrc=00.
//   - ir_write=pc_write=1 only in the cycle mem_ready=1; op_q/fn_q load on that edge; -> DECODE.
//   - Otherwise hold in FETCH.
//  DECODE: alu_srcx=0, alu_srcy=11, fn_class=10 (branch target into z).
//   - j: pc_write=1, PCsrc=01 -> FETCH.
//   - jal: as j, plus reg_write=1, reg_dst=10, reg_insrc=10.
//   - jr: pc_write=1, PCsrc=10 -> FETCH.
//   - syscall, or undecoded with TRAP_EN=1 -> TRAP. Undecoded with TRAP_EN=0 -> FETCH.
//   - Everything else -> EXEC.
//  EXEC: alu_srcx=1; alu_srcy=01 for R-type/branch, 10 for immediate/lw/sw.
//   - add/addi/lw/sw: add_sub=0, fn_class=10. sub: add_sub=1, fn_class=10.
//   - slt/slti: add_sub=1, fn_class=01. lui: fn_class=00.
//   - and/or/xor/nor and andi/ori/xori: fn_class=11, logic_fn=00/01/10/11.
//   - Branches: pc_write_cond=1, PCsrc=11, brtype per encoding -> FETCH.
//   - lw -> MEMRD; sw -> MEMWR; else -> WBALU.
//  MEMRD: inst_data=1, data_read=1; hold until mem_ready -> WBMEM.
//  MEMWR: inst_data=1, data_write=1; hold until mem_ready -> FETCH.
//  WBALU: reg_write=1, reg_insrc=01, reg_dst=01 if R-type else 00 -> FETCH.
//  WBMEM: reg_write=1, reg_insrc=00, reg_dst=00 -> FETCH.
//  TRAP: pc_write=1, PCsrc=01, jump_addr=1, illegal=1 iff undecoded (0 for syscall) -> FETCH.
//  mem_ready is ignored outside FETCH/MEMRD/MEMWR.
//  retire_cnt: +1 on each edge that enters FETCH from a non-FETCH state; wraps 2^CNT_W-1 -> 0.
//  Latency with mem_ready=1: j/jr 2, branch 3, trap 3, ALU 4, sw 4, lw 5 cycles.
// TESTING
//  - rst then add (op 0, fn 100000), mem_ready=1 -> states FETCH,DECODE,EXEC,WBALU,FETCH; WBALU reg_write=1, reg_dst=01; retire_cnt=1.
//  - lw, mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles with data_read=inst_data=1; WBMEM reg_insrc=00; 8 cycles total.
//  - beq -> EXEC pc_write_cond=1, brtype=01, PCsrc=11; jal -> DECODE pc_write=1, PCsrc=01, reg_dst=10, reg_insrc=10.
//  - op 111111, TRAP_EN=1 -> TRAP, illegal=1, jump_addr=1; syscall -> illegal=0; TRAP_EN=0 -> FETCH, no pc_write/reg_write.
//  - CNT_W=2, 5 instrs -> retire_cnt 1,2,3,0,1; rst in MEMWR -> FETCH next cycle, data_write=0, retire_cnt=0.

Source files
------------

// File: rtl/micromips_mc_control.sv
// Purpose : multicycle control FSM for the MicroMIPS datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Latency : with mem_ready=1, j/jr 2, branch/trap 3, ALU/sw 4, lw 5 cycles per instruction.
// Backpr. : FETCH, MEMRD and MEMWR hold until mem_ready (when MEM_HS=1); other states ignore it.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset (forces all outputs 0 while high)
//   op, fn              - instruction fields from the memory read, captured in FETCH on mem_ready
//   mem_ready           - memory access complete this cycle
//   pc_write ... illegal - Moore datapath controls decoded from state and the captured op/fn
//   retire_cnt          - count of completed instructions, wraps at 2^CNT_W
module micromips_mc_control #(
  parameter int MEM_HS  = 1,
  parameter int TRAP_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       fn,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             inst_data,
  output logic             data_read,
  output logic             data_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       reg_insrc,
  output logic             alu_srcx,
  output logic [1:0]       alu_srcy,
  output logic             add_sub,
  output logic [1:0]       logic_fn,
  output logic [1:0]       fn_class,
  output logic [1:0]       brtype,
  output logic [1:0]       PCsrc,
  output logic             jump_addr,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4,
    WBALU  = 3'd5,
    WBMEM  = 3'd6,
    TRAP   = 3'd7
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // R-type function codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SYS  = 6'b001100;

  state_t     state, next_state;
  logic [5:0] op_q, fn_q;
  logic       ready;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;

  // Instruction decode from the captured fields
  logic is_r;
  logic r_add, r_sub, r_slt, r_and, r_or, r_xor, r_nor, r_jr, r_sys;
  logic i_lui, i_addi, i_slti, i_andi, i_ori, i_xori, i_lw, i_sw;
  logic i_j, i_jal, i_bltz, i_beq, i_bne;
  logic is_branch, decoded;

  always_comb begin
    is_r   = (op_q == OP_RTYPE);
    r_add  = is_r && (fn_q == FN_ADD);
    r_sub  = is_r && (fn_q == FN_SUB);
    r_slt  = is_r && (fn_q == FN_SLT);
    r_and  = is_r && (fn_q == FN_AND);
    r_or   = is_r && (fn_q == FN_OR);
    r_xor  = is_r && (fn_q == FN_XOR);
    r_nor  = is_r && (fn_q == FN_NOR);
    r_jr   = is_r && (fn_q == FN_JR);
    r_sys  = is_r && (fn_q == FN_SYS);
    i_lui  = (op_q == OP_LUI);
    i_addi = (op_q == OP_ADDI);
    i_slti = (op_q == OP_SLTI);
    i_andi = (op_q == OP_ANDI);
    i_ori  = (op_q == OP_ORI);
    i_xori = (op_q == OP_XORI);
    i_lw   = (op_q == OP_LW);
    i_sw   = (op_q == OP_SW);
    i_j    = (op_q == OP_J);
    i_jal  = (op_q == OP_JAL);
    i_bltz = (op_q == OP_BLTZ);
    i_beq  = (op_q == OP_BEQ);
    i_bne  = (op_q == OP_BNE);
    is_branch = i_bltz || i_beq || i_bne;
    decoded = r_add || r_sub || r_slt || r_and || r_or || r_xor || r_nor || r_jr || r_sys ||
              i_lui || i_addi || i_slti || i_andi || i_ori || i_xori || i_lw || i_sw ||
              i_j || i_jal || is_branch;
  end

  // State, captured instruction fields and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      op_q       <= '0;
      fn_q       <= '0;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH && ready) begin
        op_q <= op;
        fn_q <= fn;
      end
      // An instruction retires whenever control returns to FETCH.
      if (state != FETCH && next_state == FETCH)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Next state and Moore outputs
  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    inst_data     = 1'b0;
    data_read     = 1'b0;
    data_write    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    reg_insrc     = 2'b00;
    alu_srcx      = 1'b0;
    alu_srcy      = 2'b00;
    add_sub       = 1'b0;
    logic_fn      = 2'b00;
    fn_class      = 2'b00;
    brtype        = 2'b00;
    PCsrc         = 2'b00;
    jump_addr     = 1'b0;
    illegal       = 1'b0;

    if (!rst) begin
      unique case (state)
        FETCH: begin
          // ALU computes PC+4 while memory returns the instruction.
          data_read = 1'b1;
          fn_class  = 2'b10;
          if (ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
          end
        end

        DECODE: begin
          // Precompute the branch target into z in case this is a branch.
          alu_srcy = 2'b11;
          fn_class = 2'b10;
          if (i_j || i_jal) begin
            pc_write   = 1'b1;
            PCsrc      = 2'b01;
            next_state = FETCH;
            if (i_jal) begin
              reg_write = 1'b1;
              reg_dst   = 2'b10;
              reg_insrc = 2'b10;
            end
          end else if (r_jr) begin
            pc_write   = 1'b1;
            PCsrc      = 2'b10;
            next_state = FETCH;
          end else if (r_sys || (!decoded && TRAP_EN != 0)) begin
            next_state = TRAP;
          end else if (!decoded) begin
            next_state = FETCH;
          end else begin
            next_state = EXEC;
          end
        end

        EXEC: begin
          alu_srcx = 1'b1;
          alu_srcy = (is_r || is_branch) ? 2'b01 : 2'b10;
          if (r_add || i_addi || i_lw || i_sw) begin
            fn_class = 2'b10;
          end else if (r_sub) begin
            add_sub  = 1'b1;
            fn_class = 2'b10;
          end else if (r_slt || i_slti) begin
            add_sub  = 1'b1;
            fn_class = 2'b01;
          end else if (i_lui) begin
            fn_class = 2'b00;
          end else if (r_and || i_andi) begin
            fn_class = 2'b11;
            logic_fn = 2'b00;
          end else if (r_or || i_ori) begin
            fn_class = 2'b11;
            logic_fn = 2'b01;
          end else if (r_xor || i_xori) begin
            fn_class = 2'b11;
            logic_fn = 2'b10;
          end else if (r_nor) begin
            fn_class = 2'b11;
            logic_fn = 2'b11;
          end

          if (is_branch) begin
            pc_write_cond = 1'b1;
            PCsrc         = 2'b11;
            brtype        = i_beq ? 2'b01 : (i_bne ? 2'b10 : 2'b11);
            next_state    = FETCH;
          end else if (i_lw) begin
            next_state = MEMRD;
          end else if (i_sw) begin
            next_state = MEMWR;
          end else begin
            next_state = WBALU;
          end
        end

        MEMRD: begin
          inst_data = 1'b1;
          data_read = 1'b1;
          if (ready) next_state = WBMEM;
        end

        MEMWR: begin
          inst_data  = 1'b1;
          data_write = 1'b1;
          if (ready) next_state = FETCH;
        end

        WBALU: begin
          reg_write  = 1'b1;
          reg_insrc  = 2'b01;
          reg_dst    = is_r ? 2'b01 : 2'b00;
          next_state = FETCH;
        end

        WBMEM: begin
          reg_write  = 1'b1;
          reg_insrc  = 2'b00;
          reg_dst    = 2'b00;
          next_state = FETCH;
        end

        TRAP: begin
          pc_write   = 1'b1;
          PCsrc      = 2'b01;
          jump_addr  = 1'b1;
          illegal    = !r_sys;
          next_state = FETCH;
        end

        default: next_state = FETCH;
      endcase
    end
  end

endmodule
